// File: rtl/isp_seq_ctrl.sv
// Frame sequencer for the ISP pipeline: tracks raster position and Bayer phase,
// strobes the scanline buffer, and runs a stall-correct 3-stage valid chain.
module isp_seq_ctrl #(
  parameter int XW = 12,
  parameter int YW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x_size,
  input  logic [YW-1:0] y_size,
  input  logic          sub_valid,
  output logic          sub_ready,
  input  logic          out_ready,
  output logic [1:0]    bayer_phase,
  output logic [XW-1:0] lb_addr,
  output logic          lb_wr_en,
  output logic          lb_rd_en,
  output logic          en_cs,
  output logic          en_cc,
  output logic          en_out,
  output logic          data_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, xs_q, xs_d;
  logic [YW-1:0] y_q, y_d, ys_q, ys_d;
  logic          v_cs_q, v_cs_d, v_cc_q, v_cc_d, v_out_q, v_out_d;

  logic adv_out, adv_cc, adv_cs;
  logic run_ready, accept, issue, cfg_ok, x_last, y_last, pipe_empty;

  // A stage may load when it is empty or its content moves on this cycle.
  assign adv_out    = !v_out_q | out_ready;
  assign adv_cc     = !v_cc_q  | adv_out;
  assign adv_cs     = !v_cs_q  | adv_cc;

  assign run_ready  = (state_q == RUN) & adv_cs;
  assign accept     = sub_valid & run_ready;
  assign issue      = accept & y_q[0] & x_q[0];
  assign x_last     = (x_q == xs_q - XW'(1));
  assign y_last     = (y_q == ys_q - YW'(1));
  assign pipe_empty = !v_cs_q & !v_cc_q & !v_out_q;
  assign cfg_ok     = !x_size[0] && !y_size[0] && (x_size >= XW'(2)) && (y_size >= YW'(2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && cfg_ok) state_d = RUN;
      RUN:     if (accept && x_last && y_last) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sub_ready   = run_ready;
    busy        = (state_q != IDLE);
    frame_done  = (state_q == DRAIN) & pipe_empty;
    cfg_err     = (state_q == IDLE) & start & !cfg_ok;
    lb_wr_en    = accept & !y_q[0];
    lb_rd_en    = accept & y_q[0];
    lb_addr     = x_q;
    bayer_phase = {y_q[0], x_q[0]};
    en_cs       = issue;
    en_cc       = v_cs_q & adv_cc;
    en_out      = v_cc_q & adv_out;
    data_ready  = v_out_q;
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    xs_d = xs_q;
    ys_d = ys_q;
    if (state_q == IDLE && start && cfg_ok) begin
      xs_d = x_size;
      ys_d = y_size;
    end
    if (accept) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // A stage stays valid if it loads, or if it is full and cannot hand off.
  always_comb begin
    v_cs_d  = issue  | (v_cs_q  & !adv_cc);
    v_cc_d  = en_cc  | (v_cc_q  & !adv_out);
    v_out_d = en_out | (v_out_q & !out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      v_cs_q  <= 1'b0;
      v_cc_q  <= 1'b0;
      v_out_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      v_cs_q  <= v_cs_d;
      v_cc_q  <= v_cc_d;
      v_out_q <= v_out_d;
    end
  end

endmodule

// File: doc/isp_seq_ctrl.md
Name: isp_seq_ctrl

Overview:
Frame sequencer for the ISP pipeline. It accepts the raw Bayer subpixel stream and tracks x/y position and Bayer phase, and it drives the scanline-buffer write/read strobes. It also issues the per-stage register load enables (colour scaling, colorspace conversion, output) with valid tracking and backpressure. It sits between the sensor-side subpixel input and the isp_top datapath and replaces ad-hoc enable chaining with a stall-correct valid pipeline.

Parameters:
XW, 12, width of x_size and the x counter
YW, 12, width of y_size and the y counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a frame; honoured only in IDLE
x_size  in  XW  subpixels per scanline; sampled on accepted start
y_size  in  YW  scanlines per frame; sampled on accepted start
sub_valid  in  1  subpixel present on datapath input
sub_ready  out  1  controller accepts subpixel this cycle
out_ready  in  1  downstream consumes pixel_out
bayer_phase  out  2  {y[0], x[0]} of the current input subpixel
lb_addr  out  XW  scanline buffer address (= x)
lb_wr_en  out  1  write subpixel into scanline buffer
lb_rd_en  out  1  read even-line subpixel at lb_addr (asynchronous read)
en_cs  out  1  load colour-scaling stage register
en_cc  out  1  load colorspace stage register
en_out  out  1  load output register
data_ready  out  1  output register holds a valid pixel
busy  out  1  not IDLE
frame_done  out  1  one-cycle pulse after last pixel leaves output register
cfg_err  out  1  one-cycle pulse: start rejected for bad size

Behaviour:
- Reset (async): state IDLE; x, y, sampled sizes, v_cs, v_cc, v_out = 0. All outputs 0, bayer_phase 0.
- States: IDLE, RUN, DRAIN.
- IDLE: sub_ready = 0. If start and x_size, y_size both even and >= 2, latch sizes and go to RUN next cycle. If start and a size is odd or < 2, pulse cfg_err and stay in IDLE.
- start outside IDLE is ignored. No cfg_err is raised in that case.
- Stall chain (combinational):
  - adv_out = !v_out | out_ready
  - adv_cc = !v_cc | adv_out
  - adv_cs = !v_cs | adv_cc
- RUN: sub_ready = adv_cs. accept = sub_valid & sub_ready.
- On accept:
  - Even y: lb_wr_en = 1.
  - Odd y: lb_rd_en = 1.
  - lb_addr = x. bayer_phase = {y[0], x[0]} at all times in RUN.
- issue = accept & y[0] & x[0]: the 2x2 quad is complete. en_cs = issue, and v_cs <= 1.
- v_cs clears when it advances with no new issue.
- en_cc = v_cs & adv_cc. en_out = v_cc & adv_out. Valid bits shift on these enables.
- Simultaneous load and drain in the same stage keeps valid = 1.
- data_ready = v_out.
- Latency: issue at cycle t gives data_ready at t+3 with no stall. Throughput is 1 issue per cycle when unstalled.
- Counters advance only on accept:
  - x increments.
  - At x = x_size-1, x wraps to 0 and y increments.
  - Accept at x = x_size-1, y = y_size-1 moves to DRAIN; x, y clear to 0.
- DRAIN: sub_ready = 0. Stages continue to advance. When v_cs, v_cc, v_out are all 0, pulse frame_done and go to IDLE.
- start in the frame_done cycle is ignored. A new frame can start the following cycle.
- Output pixels per frame = (x_size/2) * (y_size/2).
- sub_valid while out_ready is held low: input stalls only once all three stages are full. Up to 3 quads may be buffered.
- Reset mid-frame: immediate abort, all valids dropped, no frame_done.

Test Plan:
- 4x2 frame, out_ready = 1, sub_valid continuous -> 8 accepts. lb_wr_en on accepts 0-3, lb_rd_en on 4-7. en_cs at accepts 5 and 7. data_ready 3 cycles after each. frame_done exactly 1 cycle after the last pixel leaves. Total 2 pixels.
- 2x2 minimum frame -> 1 pixel. bayer_phase sequence 0,1,2,3. busy high from the cycle after start through the frame_done cycle.
- 8x4 frame, out_ready low for 10 cycles starting after the first data_ready -> sub_ready drops once v_cs, v_cc, v_out are all 1. No pixel lost or duplicated. 8 pixels total in raster order.
- start with x_size = 5 or y_size = 0 -> single cfg_err pulse, busy stays 0, sub_ready stays 0.
- Reset asserted mid-row on the second line of a 4x4 frame -> all outputs 0 asynchronously, no frame_done. A following 4x4 frame then completes with 4 pixels.
- start pulsed during RUN and DRAIN -> ignored, sizes unchanged. A back-to-back start the cycle after frame_done is accepted.
